// File: rtl/digitization_pkg.sv
// Shared types and defaults for the digitization sequencer slice.
package digitization_pkg;

    localparam int WIN_W_DEF = 9;
    localparam int CNT_W_DEF = 12;
    localparam int NWIN_W    = 4;
    localparam int SETUP_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RAMP  = 3'd2,
        ST_XFER  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_e;

    // A zero SETUP length still needs one clear cycle.
    function automatic logic [SETUP_W-1:0] setup_min1(input logic [SETUP_W-1:0] len);
        logic [SETUP_W-1:0] res;
        if (len == 8'd0) begin
            res = 8'd1;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Down-counting phase timer: load a length, expire pulses in the last cycle.
module seq_timer
    import digitization_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    localparam logic [W-1:0] ONE_C  = W'(1);
    localparam logic [W-1:0] ZERO_C = W'(0);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over load, otherwise count down to zero and park.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = ZERO_C;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != ZERO_C) begin
            cnt_d = cnt_q - ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= ZERO_C;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count of one means this is the final cycle of the phase.
    assign expire_o = (cnt_q == ONE_C);

endmodule

// File: rtl/digitization_sequencer.sv
// Sequences SETUP/RAMP/XFER over a run of storage windows for a Wilkinson ADC.
module digitization_sequencer
    import digitization_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WIN_W-1:0]  win_addr_i,
    input  logic [NWIN_W-1:0] n_win_i,
    input  logic [SETUP_W-1:0] setup_len_i,
    input  logic [CNT_W-1:0]  ramp_len_i,
    input  logic              xfer_ack_i,
    output logic [WIN_W-1:0]  rd_addr_o,
    output logic              clr_o,
    output logic              ramp_o,
    output logic              xfer_req_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o
);

    localparam logic [CNT_W-1:0]  CNT_ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO_C = CNT_W'(0);
    localparam logic [WIN_W-1:0]  WIN_ONE_C  = WIN_W'(1);
    localparam logic [WIN_W-1:0]  WIN_ZERO_C = WIN_W'(0);
    localparam logic [NWIN_W-1:0] NW_ONE_C   = NWIN_W'(1);
    localparam logic [NWIN_W-1:0] NW_ZERO_C  = NWIN_W'(0);

    seq_state_e          state_q, state_d;
    logic [WIN_W-1:0]    rd_addr_q, rd_addr_d;
    logic [NWIN_W-1:0]   rem_q, rem_d;
    logic [SETUP_W-1:0]  setup_len_q, setup_len_d;
    logic [CNT_W-1:0]    ramp_len_q, ramp_len_d;
    logic                clr_q, clr_d;
    logic                ramp_q, ramp_d;
    logic                xfer_req_q, xfer_req_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    logic                tmr_clear_s;
    logic                tmr_load_s;
    logic [CNT_W-1:0]    tmr_val_s;
    logic                tmr_expire_s;
    logic [CNT_W-1:0]    ramp_in_min1_s;

    seq_timer #(.W(CNT_W)) u_timer (
        .clk_i      (ACLK),
        .rst_ni     (ARESETN),
        .clear_i    (tmr_clear_s),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .expire_o   (tmr_expire_s)
    );

    // A zero RAMP length still enables the ramp for one cycle.
    always_comb begin
        if (ramp_len_i == CNT_ZERO_C) begin
            ramp_in_min1_s = CNT_ONE_C;
        end else begin
            ramp_in_min1_s = ramp_len_i;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rem_d       = rem_q;
        setup_len_d = setup_len_q;
        ramp_len_d  = ramp_len_q;
        overrun_d   = overrun_q;
        tmr_clear_s = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_val_s   = CNT_ZERO_C;

        // A start that arrives mid-run is dropped but remembered.
        if (start_i && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    overrun_d   = 1'b0;
                    setup_len_d = setup_min1(setup_len_i);
                    ramp_len_d  = ramp_in_min1_s;
                    rem_d       = n_win_i;
                    if (n_win_i != NW_ZERO_C) begin
                        rd_addr_d  = win_addr_i;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = CNT_W'(setup_min1(setup_len_i));
                        state_d    = ST_SETUP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (abort_i) begin
                    tmr_clear_s = 1'b1;
                    state_d     = ST_IDLE;
                end else if (tmr_expire_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = ramp_len_q;
                    state_d    = ST_RAMP;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_RAMP: begin
                if (abort_i) begin
                    tmr_clear_s = 1'b1;
                    state_d     = ST_IDLE;
                end else if (tmr_expire_s) begin
                    state_d = ST_XFER;
                end else begin
                    state_d = ST_RAMP;
                end
            end
            ST_XFER: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (xfer_ack_i) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_NEXT: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = rem_q - NW_ONE_C;
                    if (rem_q != NW_ONE_C) begin
                        rd_addr_d  = rd_addr_q + WIN_ONE_C;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = CNT_W'(setup_len_q);
                        state_d    = ST_SETUP;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                tmr_clear_s = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the decoded next state.
        clr_d      = (state_d == ST_SETUP);
        ramp_d     = (state_d == ST_RAMP);
        xfer_req_d = (state_d == ST_XFER);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= WIN_ZERO_C;
            rem_q       <= NW_ZERO_C;
            setup_len_q <= 8'd0;
            ramp_len_q  <= CNT_ZERO_C;
            clr_q       <= 1'b0;
            ramp_q      <= 1'b0;
            xfer_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rem_q       <= rem_d;
            setup_len_q <= setup_len_d;
            ramp_len_q  <= ramp_len_d;
            clr_q       <= clr_d;
            ramp_q      <= ramp_d;
            xfer_req_q  <= xfer_req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rd_addr_o  = rd_addr_q;
    assign clr_o      = clr_q;
    assign ramp_o     = ramp_q;
    assign xfer_req_o = xfer_req_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_digitization_sequencer.sv
// Directed self-checking bench for digitization_sequencer.
module tb_digitization_sequencer;
    import digitization_pkg::*;

    localparam int WIN_W = 9;
    localparam int CNT_W = 12;

    logic              ACLK;
    logic              ARESETN;
    logic              start_i;
    logic              abort_i;
    logic [WIN_W-1:0]  win_addr_i;
    logic [3:0]        n_win_i;
    logic [7:0]        setup_len_i;
    logic [CNT_W-1:0]  ramp_len_i;
    logic              xfer_ack_i;
    logic [WIN_W-1:0]  rd_addr_o;
    logic              clr_o;
    logic              ramp_o;
    logic              xfer_req_o;
    logic              busy_o;
    logic              done_o;
    logic              overrun_o;

    int checks;
    int errors;
    int n_clr;
    int n_ramp;
    int n_done;
    int b_clr;
    int b_ramp;
    int b_done;

    digitization_sequencer #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .win_addr_i  (win_addr_i),
        .n_win_i     (n_win_i),
        .setup_len_i (setup_len_i),
        .ramp_len_i  (ramp_len_i),
        .xfer_ack_i  (xfer_ack_i),
        .rd_addr_o   (rd_addr_o),
        .clr_o       (clr_o),
        .ramp_o      (ramp_o),
        .xfer_req_o  (xfer_req_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Cycle counters for the pulse-width checks, sampled mid-cycle.
    initial begin
        n_clr = 0;
        n_ramp = 0;
        n_done = 0;
    end
    always @(negedge ACLK) begin
        if (clr_o)  n_clr++;
        if (ramp_o) n_ramp++;
        if (done_o) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // Wait for a signal: 0 = xfer_req_o, 1 = ramp_o, 2 = done_o.
    task automatic wait_for(input int which, input int budget, input string tag);
        int  k;
        logic s;
        k = 0;
        s = (which == 0) ? xfer_req_o : ((which == 1) ? ramp_o : done_o);
        while (s !== 1'b1 && k < budget) begin
            step();
            k++;
            s = (which == 0) ? xfer_req_o : ((which == 1) ? ramp_o : done_o);
        end
        chk(tag, 32'(s), 32'd1);
    endtask

    task automatic start_run(input logic [WIN_W-1:0] a, input logic [3:0] n,
                             input logic [7:0] sl, input logic [CNT_W-1:0] rl);
        win_addr_i  = a;
        n_win_i     = n;
        setup_len_i = sl;
        ramp_len_i  = rl;
        start_i     = 1'b1;
        step();
        start_i     = 1'b0;
    endtask

    task automatic ack_once();
        xfer_ack_i = 1'b1;
        step();
        xfer_ack_i = 1'b0;
    endtask

    task automatic snap();
        b_clr  = n_clr;
        b_ramp = n_ramp;
        b_done = n_done;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ARESETN = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        win_addr_i = '0;
        n_win_i = 4'd0;
        setup_len_i = 8'd0;
        ramp_len_i = '0;
        xfer_ack_i = 1'b0;

        // Reset state
        step();
        step();
        chk("reset_outputs", 32'({rd_addr_o, clr_o, ramp_o, xfer_req_o, busy_o, done_o, overrun_o}), 32'd0);
        ARESETN = 1'b1;
        step();
        chk("idle_after_reset", 32'({busy_o, done_o}), 32'd0);

        // Single window, setup 4, ramp 100, late ack; stray ack in SETUP ignored
        snap();
        start_run(9'd37, 4'd1, 8'd4, 12'd100);
        chk("t1_busy_rise", 32'({busy_o, clr_o}), 32'd3);
        chk("t1_addr_setup", 32'(rd_addr_o), 32'd37);
        ack_once();
        wait_for(0, 200, "t1_xfer_timeout");
        chk("t1_clr_cycles", 32'(n_clr - b_clr), 32'd4);
        chk("t1_ramp_cycles", 32'(n_ramp - b_ramp), 32'd100);
        chk("t1_addr_xfer", 32'(rd_addr_o), 32'd37);
        step();
        step();
        chk("t1_xfer_held", 32'(xfer_req_o), 32'd1);
        ack_once();
        chk("t1_next", 32'({xfer_req_o, busy_o, done_o}), 32'b010);
        step();
        chk("t1_done", 32'({done_o, busy_o}), 32'b11);
        step();
        chk("t1_idle", 32'({done_o, busy_o}), 32'd0);
        chk("t1_done_count", 32'(n_done - b_done), 32'd1);

        // Address wrap across three windows
        snap();
        start_run(9'd510, 4'd3, 8'd1, 12'd2);
        wait_for(0, 50, "t2_xfer0_timeout");
        chk("t2_addr0", 32'(rd_addr_o), 32'd510);
        ack_once();
        wait_for(0, 50, "t2_xfer1_timeout");
        chk("t2_addr1", 32'(rd_addr_o), 32'd511);
        ack_once();
        wait_for(0, 50, "t2_xfer2_timeout");
        chk("t2_addr2", 32'(rd_addr_o), 32'd0);
        ack_once();
        wait_for(2, 10, "t2_done_timeout");
        step();
        chk("t2_done_count", 32'(n_done - b_done), 32'd1);
        chk("t2_idle", 32'({busy_o, done_o}), 32'd0);

        // Empty run: straight to DONE, no clear or ramp
        snap();
        start_run(9'd12, 4'd0, 8'd3, 12'd3);
        chk("t3_done", 32'({done_o, busy_o, clr_o, ramp_o}), 32'b1100);
        step();
        chk("t3_idle", 32'({done_o, busy_o}), 32'd0);
        step();
        chk("t3_no_clr_ramp", 32'((n_clr - b_clr) + (n_ramp - b_ramp)), 32'd0);
        chk("t3_done_count", 32'(n_done - b_done), 32'd1);

        // Zero lengths behave as one cycle each
        snap();
        start_run(9'd3, 4'd1, 8'd0, 12'd0);
        wait_for(0, 10, "t4_xfer_timeout");
        chk("t4_clr_cycles", 32'(n_clr - b_clr), 32'd1);
        chk("t4_ramp_cycles", 32'(n_ramp - b_ramp), 32'd1);
        ack_once();
        wait_for(2, 5, "t4_done_timeout");
        step();

        // Start during RAMP sets overrun and is otherwise ignored
        snap();
        start_run(9'd7, 4'd1, 8'd2, 12'd10);
        wait_for(1, 10, "t5_ramp_timeout");
        step();
        start_run(9'd99, 4'd2, 8'd1, 12'd1);
        chk("t5_overrun_set", 32'(overrun_o), 32'd1);
        chk("t5_run_kept", 32'({rd_addr_o, ramp_o}), 32'({9'd7, 1'b1}));
        wait_for(0, 20, "t5_xfer_timeout");
        ack_once();
        wait_for(2, 5, "t5_done_timeout");
        step();
        chk("t5_done_count", 32'(n_done - b_done), 32'd1);
        chk("t5_overrun_sticky", 32'(overrun_o), 32'd1);
        start_run(9'd5, 4'd1, 8'd1, 12'd1);
        chk("t5_overrun_clear", 32'({overrun_o, rd_addr_o}), 32'({1'b0, 9'd5}));
        wait_for(0, 10, "t5b_xfer_timeout");
        ack_once();
        wait_for(2, 5, "t5b_done_timeout");
        step();

        // Abort together with ack in XFER, then a fresh run
        snap();
        start_run(9'd100, 4'd2, 8'd1, 12'd1);
        wait_for(0, 10, "t6_xfer_timeout");
        abort_i = 1'b1;
        xfer_ack_i = 1'b1;
        step();
        abort_i = 1'b0;
        xfer_ack_i = 1'b0;
        chk("t6_abort_idle", 32'({busy_o, clr_o, ramp_o, xfer_req_o, done_o}), 32'd0);
        step();
        step();
        chk("t6_no_done", 32'(n_done - b_done), 32'd0);
        start_run(9'd200, 4'd1, 8'd1, 12'd1);
        chk("t6_restart", 32'({busy_o, rd_addr_o}), 32'({1'b1, 9'd200}));
        wait_for(0, 10, "t6b_xfer_timeout");
        ack_once();
        wait_for(2, 5, "t6b_done_timeout");
        step();
        chk("t6_done_count", 32'(n_done - b_done), 32'd1);

        // Abort with start in IDLE: start dropped, no overrun
        abort_i = 1'b1;
        start_run(9'd44, 4'd1, 8'd1, 12'd1);
        abort_i = 1'b0;
        chk("t7_abort_start", 32'({busy_o, overrun_o}), 32'd0);

        // Asynchronous reset during SETUP, start accepted on first edge after release
        snap();
        start_run(9'd60, 4'd1, 8'd8, 12'd5);
        step();
        #2;
        ARESETN = 1'b0;
        #1;
        chk("t8_async_reset", 32'({rd_addr_o, clr_o, ramp_o, xfer_req_o, busy_o, done_o, overrun_o}), 32'd0);
        step();
        ARESETN = 1'b1;
        start_run(9'd33, 4'd1, 8'd1, 12'd1);
        chk("t8_start_after_reset", 32'({busy_o, clr_o, rd_addr_o}), 32'({2'b11, 9'd33}));
        wait_for(0, 10, "t8_xfer_timeout");
        ack_once();
        wait_for(2, 5, "t8_done_timeout");
        step();
        chk("t8_done_count", 32'(n_done - b_done), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
